// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings, conf layout and data-length limits for the UART engines
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK, ST_DONE} tx_state_e;
  typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10, PAR_MARK = 2'b11} parity_e;
  typedef enum logic [1:0] {STOP_1 = 2'b00, STOP_1P5 = 2'b01, STOP_2 = 2'b10, STOP_2B = 2'b11} stop_e;
  localparam int CONF_PAR_LSB = 0;
  localparam int CONF_PAR_W = 2;
  localparam int CONF_STOP_LSB = 2;
  localparam int CONF_STOP_W = 2;
  localparam int CONF_LEN_LSB = 4;
  localparam int CONF_LEN_W = 4;
  localparam logic [3:0] DATA_LEN_MIN = 4'd5;
  localparam logic [3:0] DATA_LEN_MAX = 4'd15;
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    logic [3:0] hi;
    hi = max_len > DATA_LEN_MAX ? DATA_LEN_MAX : max_len;
    return len < DATA_LEN_MIN ? DATA_LEN_MIN : (len > hi ? hi : len);
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: baud-tick counter flagging the last tick of a full bit and of a half bit
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16,
  parameter int SAMPLE_COUNT_WIDTH = $clog2(OVERSAMPLE)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic full_o,
  output logic half_o
);
  localparam logic [SAMPLE_COUNT_WIDTH-1:0] LAST = SAMPLE_COUNT_WIDTH'(OVERSAMPLE - 1);
  localparam logic [SAMPLE_COUNT_WIDTH-1:0] HALF = SAMPLE_COUNT_WIDTH'(OVERSAMPLE / 2 - 1);
  logic [SAMPLE_COUNT_WIDTH-1:0] cnt_q, cnt_d;
  assign full_o = tick_i && cnt_q == LAST;
  assign half_o = tick_i && cnt_q == HALF;
  assign cnt_d = clr_i ? '0 : !tick_i ? cnt_q : full_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: configurable-format UART transmitter with parity, 1/1.5/2 stop bits and break
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int MAX_DATA_W = 9,
  parameter int OVERSAMPLE = 16,
  parameter int SAMPLE_COUNT_WIDTH = $clog2(OVERSAMPLE),
  parameter int TOTAL_CONF_WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        baud_en_i,
  input  logic                        tx_en_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  input  logic [MAX_DATA_W-1:0]       tx_data_i,
  input  logic [TOTAL_CONF_WIDTH-1:0] tx_conf_i,
  input  logic                        break_i,
  output logic                        tx_done_o,
  output logic                        tx_busy_o,
  output logic                        uart_tx_o
);
  tx_state_e state_q;
  stop_e stop_q;
  logic [MAX_DATA_W-1:0] shreg_q;
  logic [3:0] len_q, bit_q, len_d;
  logic par_en_q, par_q, mark_q, tx_q, busy_q, done_q;
  logic bit_full, bit_half, timer_clr, accept, par_raw, par_d, stop_end;
  parity_e pmode;
  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE), .SAMPLE_COUNT_WIDTH(SAMPLE_COUNT_WIDTH)) u_timer (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(timer_clr), .tick_i(baud_en_i),
    .full_o(bit_full), .half_o(bit_half)
  );
  assign timer_clr = state_q inside {ST_IDLE, ST_BREAK, ST_DONE};
  assign tx_ready_o = (state_q == ST_IDLE) && tx_en_i && !break_i && !rst_i;
  assign accept = tx_valid_i && tx_ready_o;
  assign pmode = parity_e'(tx_conf_i[CONF_PAR_LSB +: CONF_PAR_W]);
  assign len_d = clamp_len(tx_conf_i[CONF_LEN_LSB +: CONF_LEN_W], 4'(MAX_DATA_W));
  assign par_raw = ^(tx_data_i & MAX_DATA_W'((32'd1 << len_d) - 32'd1));
  assign par_d = (pmode == PAR_MARK) || (par_raw ^ (pmode == PAR_ODD));
  // 1.5 stop bits end on the half-bit mark of the second stop bit
  assign stop_end = (stop_q == STOP_1 && bit_full) ||
                    (stop_q == STOP_1P5 && bit_q == 4'd1 && bit_half) ||
                    ((stop_q == STOP_2 || stop_q == STOP_2B) && bit_q == 4'd1 && bit_full);
  assign uart_tx_o = tx_q;
  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      stop_q   <= STOP_1;
      shreg_q  <= '0;
      len_q    <= DATA_LEN_MIN;
      bit_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      mark_q   <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tx_q <= (state_q == ST_START || state_q == ST_BREAK) ? 1'b0 :
              state_q == ST_DATA ? shreg_q[0] :
              state_q == ST_PARITY ? par_q : 1'b1;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE:
          if (break_i) begin
            state_q <= ST_BREAK;
            busy_q  <= 1'b1;
          end else if (accept) begin
            state_q  <= ST_START;
            busy_q   <= 1'b1;
            shreg_q  <= tx_data_i;
            len_q    <= len_d;
            stop_q   <= stop_e'(tx_conf_i[CONF_STOP_LSB +: CONF_STOP_W]);
            par_en_q <= pmode != PAR_NONE;
            par_q    <= par_d;
            mark_q   <= 1'b0;
            bit_q    <= '0;
          end
        ST_START: if (bit_full) state_q <= ST_DATA;
        ST_DATA:
          if (bit_full) begin
            shreg_q <= shreg_q >> 1;
            bit_q   <= bit_q + 4'd1;
            if (bit_q == len_q - 4'd1) begin
              state_q <= par_en_q ? ST_PARITY : ST_STOP;
              bit_q   <= '0;
            end
          end
        ST_PARITY: if (bit_full) state_q <= ST_STOP;
        ST_STOP: begin
          if (bit_full) bit_q <= bit_q + 4'd1;
          if (stop_end) begin
            state_q <= mark_q ? ST_IDLE : ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= !mark_q;
          end
        end
        // leaving break reuses the stop state as a one-bit mark without a done pulse
        ST_BREAK:
          if (!break_i) begin
            state_q <= ST_STOP;
            stop_q  <= STOP_1;
            mark_q  <= 1'b1;
            bit_q   <= '0;
          end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: randomized bench comparing the line against a per-tick waveform model
module tb_uart_tx_engine;
  localparam int MAX_W = 9;
  localparam int OS = 16;
  typedef enum {P_IDLE, P_FRAME, P_DONE, P_BREAK, P_MARK} ph_e;
  logic clk = 1'b0, rst_i = 1'b1, baud_en_i = 1'b0, tx_en_i = 1'b1, tx_valid_i = 1'b0, break_i = 1'b0;
  logic [MAX_W-1:0] tx_data_i = '0;
  logic [7:0] tx_conf_i = '0;
  logic tx_ready_o, tx_done_o, tx_busy_o, uart_tx_o;
  int n_chk = 0, n_fail = 0, t = 0;
  bit fast = 1'b1, accepted = 1'b0;
  bit wave[$];
  ph_e ph = P_IDLE;

  uart_tx_engine #(.MAX_DATA_W(MAX_W), .OVERSAMPLE(OS)) dut (
    .clk_i(clk), .rst_i(rst_i), .baud_en_i(baud_en_i), .tx_en_i(tx_en_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
    .tx_conf_i(tx_conf_i), .break_i(break_i), .tx_done_o(tx_done_o),
    .tx_busy_o(tx_busy_o), .uart_tx_o(uart_tx_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // expected line level for every baud tick of one frame
  task automatic build(input logic [MAX_W-1:0] d, input logic [7:0] c);
    int n, mode, st;
    bit p;
    wave.delete();
    n = int'(c[7:4]);
    if (n < 5) n = 5;
    if (n > MAX_W) n = MAX_W;
    mode = int'(c[1:0]);
    st = int'(c[3:2]);
    p = 1'b0;
    repeat (OS) wave.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      repeat (OS) wave.push_back(d[i]);
      p ^= d[i];
    end
    if (mode != 0) repeat (OS) wave.push_back(mode == 3 ? 1'b1 : mode == 2 ? !p : p);
    repeat (st == 0 ? OS : st == 1 ? OS * 3 / 2 : 2 * OS) wave.push_back(1'b1);
  endtask

  task automatic cycle();
    bit line_e;
    baud_en_i = fast ? 1'b1 : ($urandom_range(0, 2) == 0);
    @(negedge clk);
    check("ready", tx_ready_o, ph == P_IDLE && tx_en_i && !break_i);
    line_e = ph == P_FRAME ? wave[t] : ph != P_BREAK;
    case (ph)
      P_IDLE:
        if (break_i) ph = P_BREAK;
        else if (tx_valid_i && tx_en_i) begin
          build(tx_data_i, tx_conf_i);
          ph = P_FRAME;
          t = 0;
          accepted = 1'b1;
        end
      P_FRAME: if (baud_en_i) begin t++; if (t == wave.size()) ph = P_DONE; end
      P_DONE: ph = P_IDLE;
      P_BREAK: if (!break_i) begin ph = P_MARK; t = 0; end
      P_MARK: if (baud_en_i) begin t++; if (t == OS) ph = P_IDLE; end
      default: ph = P_IDLE;
    endcase
    @(posedge clk);
    #1;
    check("line", uart_tx_o, line_e);
    check("busy", tx_busy_o, ph inside {P_FRAME, P_BREAK, P_MARK});
    check("done", tx_done_o, ph == P_DONE);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [MAX_W-1:0] d, input logic [7:0] c);
    int n = 0;
    tx_data_i = d;
    tx_conf_i = c;
    tx_valid_i = 1'b1;
    accepted = 1'b0;
    while (!accepted && n < 3000) begin cycle(); n++; end
    tx_valid_i = 1'b0;
    tx_data_i = MAX_W'($urandom);
    tx_conf_i = 8'($urandom);
    check("accept", accepted, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (ph != P_IDLE && n < 5000) begin cycle(); n++; end
    check("drain", ph == P_IDLE, 1'b1);
    cycle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_line", uart_tx_o, 1'b1);
    check("rst_busy", tx_busy_o, 1'b0);
    check("rst_done", tx_done_o, 1'b0);
    check("rst_ready", tx_ready_o, 1'b0);
    rst_i = 1'b0;
    run(3);
    send(9'h0A5, 8'h80); drain();
    send(9'h055, 8'h72); drain();
    send(9'h1FF, 8'h91); drain();
    send(9'h1E0, 8'h53); drain();
    send(9'h0F0, 8'h84); send(9'h00F, 8'h84); drain();
    send(9'h0A5, 8'h80); run(140); break_i = 1'b1; run(40); break_i = 1'b0; drain();
    break_i = 1'b1; run(40); break_i = 1'b0; drain();
    send(9'h0C3, 8'h80); run(55);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_line", uart_tx_o, 1'b1);
    check("arst_busy", tx_busy_o, 1'b0);
    check("arst_ready", tx_ready_o, 1'b0);
    ph = P_IDLE;
    t = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    send(9'h03C, 8'h80); drain();
    send(9'h1AB, 8'h20); drain();
    send(9'h1AB, 8'hF0); drain();
    tx_en_i = 1'b0; tx_valid_i = 1'b1; tx_data_i = 9'h012; tx_conf_i = 8'h80;
    run(30);
    tx_valid_i = 1'b0; tx_en_i = 1'b1;
    send(9'h155, 8'h83); tx_en_i = 1'b0; drain(); tx_en_i = 1'b1;
    fast = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        break_i = 1'b1; run($urandom_range(5, 40)); break_i = 1'b0; drain();
      end
      send(MAX_W'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
